meas_top_rtl: RTL and testbench

- Dual-channel measurement datapath: SPI master reads two 12-bit ADC channels over a 2-bit-wide SPI bus, filters each channel with a first-order IIR averager, and writes both averaged values to a 2-bit-wide SPI DAC.
- Top-level RTL core of the measurement system; board-level wrappers connect the SPI pins to PMOD headers.

---
 rtl/meas_top_rtl_if.sv | 29 ++
 rtl/meas_top_rtl.sv | 220 ++++++++++++++++++++++
 tb/tb_meas_top_rtl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/meas_top_rtl_if.sv
// SPI pin bundle for the ADC and DAC buses.
// Master drives CS/SCK/MOSI, slave drives MISO.
`timescale 1ns/1ps
interface meas_top_rtl_if;
  logic       adc_cs_no;
  logic       adc_sck_o;
  logic [1:0] adc_miso_i;
  logic       dac_cs_no;
  logic       dac_sck_o;
  logic [1:0] dac_mosi_o;

  modport master (
    output adc_cs_no,
    output adc_sck_o,
    input  adc_miso_i,
    output dac_cs_no,
    output dac_sck_o,
    output dac_mosi_o
  );

  modport slave (
    input  adc_cs_no,
    input  adc_sck_o,
    output adc_miso_i,
    input  dac_cs_no,
    input  dac_sck_o,
    input  dac_mosi_o
  );
endinterface

// File: rtl/meas_top_rtl.sv
// Dual-channel ADC -> IIR averager -> DAC datapath.
// Two mode-0 SPI masters share one frame engine.
`timescale 1ns/1ps
module meas_spi_eng #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] tx0,
  input  logic [15:0] tx1,
  input  logic [1:0]  miso,
  output logic        ready,
  output logic        cs_n,
  output logic        sck,
  output logic [1:0]  mosi,
  output logic [11:0] rx0,
  output logic [11:0] rx1,
  output logic        done
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] RISE = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] FALL = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_DONE
  } st_t;

  st_t           st;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   tx_sh0, tx_sh1;
  logic [11:0]   rx_sh0, rx_sh1;

  assign ready = (st == S_IDLE);
  assign mosi  = {tx_sh1[15], tx_sh0[15]};

  // Frame sequencer: CS lead, 16 SCK periods, CS trail, result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh0  <= '0;
      tx_sh1  <= '0;
      rx_sh0  <= '0;
      rx_sh1  <= '0;
      rx0     <= '0;
      rx1     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (start) begin
            cs_n   <= 1'b0;
            tx_sh0 <= tx0;
            tx_sh1 <= tx1;
            st     <= S_LEAD;
          end
        end
        S_LEAD: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          st      <= S_XFER;
        end
        S_XFER: begin
          if (div_cnt == RISE) begin
            sck    <= 1'b1;
            rx_sh0 <= {rx_sh0[10:0], miso[0]};
            rx_sh1 <= {rx_sh1[10:0], miso[1]};
          end
          if (div_cnt == FALL) begin
            sck     <= 1'b0;
            div_cnt <= '0;
            tx_sh0  <= {tx_sh0[14:0], 1'b0};
            tx_sh1  <= {tx_sh1[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) st <= S_TRAIL;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_TRAIL: begin
          cs_n <= 1'b1;
          st   <= S_DONE;
        end
        S_DONE: begin
          rx0  <= rx_sh0;
          rx1  <= rx_sh1;
          done <= 1'b1;
          st   <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

module meas_top_rtl #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 136
) (
  input  logic                clk,
  input  logic                reset_ni,
  input  logic [15:0]         sw,
  meas_top_rtl_if.master      spi,
  output logic                adc_data_update_o,
  output logic [11:0]         adc_data0_o,
  output logic [11:0]         adc_data1_o,
  output logic                avg_update_o,
  output logic [11:0]         avg0_o,
  output logic [11:0]         avg1_o
);
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("CLK_DIV must be even and >= 2");
  end
  if (SAMPLE_DIV < 2 * (16 * CLK_DIV + 4)) begin : g_bad_sample_div
    $error("SAMPLE_DIV too small for two SPI frames");
  end

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TLAST = TW'(SAMPLE_DIV - 1);

  logic [TW-1:0] tmr;
  logic          adc_start;
  logic          adc_ready_unused;
  logic [1:0]    adc_mosi_unused;

  logic          pend_v;
  logic [11:0]   pend0, pend1;
  logic          dac_ready;
  logic          dac_take;
  logic [11:0]   dac_rx0_unused, dac_rx1_unused;
  logic          dac_done_unused;
  logic          sw_unused;

  assign sw_unused = ^sw[15:2];
  assign adc_start = sw[0] && (tmr == '0);
  assign dac_take  = pend_v && dac_ready;

  // Sample timer: free-runs while enabled, parks at zero when disabled.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) tmr <= '0;
    else if (!sw[0]) tmr <= '0;
    else if (tmr == TLAST) tmr <= '0;
    else tmr <= tmr + 1'b1;
  end

  meas_spi_eng #(.CLK_DIV(CLK_DIV)) u_adc (
    .clk   (clk),
    .rst_n (reset_ni),
    .start (adc_start),
    .tx0   (16'h0000),
    .tx1   (16'h0000),
    .miso  (spi.adc_miso_i),
    .ready (adc_ready_unused),
    .cs_n  (spi.adc_cs_no),
    .sck   (spi.adc_sck_o),
    .mosi  (adc_mosi_unused),
    .rx0   (adc_data0_o),
    .rx1   (adc_data1_o),
    .done  (adc_data_update_o)
  );

  function automatic logic [11:0] iir(
    input logic [11:0] d,
    input logic [11:0] a
  );
    return (d >> 3) + (a >> 3) + (a >> 2) + (a >> 1);
  endfunction

  // First-order averager, weight 1/8 on the new sample.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      avg0_o       <= '0;
      avg1_o       <= '0;
      avg_update_o <= 1'b0;
    end else begin
      avg_update_o <= adc_data_update_o;
      if (adc_data_update_o) begin
        avg0_o <= iir(adc_data0_o, avg0_o);
        avg1_o <= iir(adc_data1_o, avg1_o);
      end
    end
  end

  // One-deep DAC mailbox; a newer pair overwrites an unsent one.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_v <= 1'b0;
      pend0  <= '0;
      pend1  <= '0;
    end else if (avg_update_o && sw[1]) begin
      pend_v <= 1'b1;
      pend0  <= avg0_o;
      pend1  <= avg1_o;
    end else if (dac_take) begin
      pend_v <= 1'b0;
    end
  end

  meas_spi_eng #(.CLK_DIV(CLK_DIV)) u_dac (
    .clk   (clk),
    .rst_n (reset_ni),
    .start (pend_v),
    .tx0   ({4'h0, pend0}),
    .tx1   ({4'h0, pend1}),
    .miso  (2'b00),
    .ready (dac_ready),
    .cs_n  (spi.dac_cs_no),
    .sck   (spi.dac_sck_o),
    .mosi  (spi.dac_mosi_o),
    .rx0   (dac_rx0_unused),
    .rx1   (dac_rx1_unused),
    .done  (dac_done_unused)
  );
endmodule

// File: tb/tb_meas_top_rtl.sv
// Bench for meas_top_rtl: SPI ADC slave, DAC capture,
// and a reference averager driven from the slave's data.
`timescale 1ns/1ps
module tb_meas_top_rtl;
  localparam int CLK_DIV    = 4;
  localparam int SAMPLE_DIV = 140;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [15:0] sw = 16'h0003;
  logic        adc_data_update_o;
  logic [11:0] adc_data0_o, adc_data1_o;
  logic        avg_update_o;
  logic [11:0] avg0_o, avg1_o;

  meas_top_rtl_if spi ();

  meas_top_rtl #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .clk               (clk),
    .reset_ni          (reset_ni),
    .sw                (sw),
    .spi               (spi),
    .adc_data_update_o (adc_data_update_o),
    .adc_data0_o       (adc_data0_o),
    .adc_data1_o       (adc_data1_o),
    .avg_update_o      (avg_update_o),
    .avg0_o            (avg0_o),
    .avg1_o            (avg1_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  logic [11:0] exp0[$], exp1[$], dexp0[$], dexp1[$];
  logic [15:0] a_sh0 = '0, a_sh1 = '0;
  logic [15:0] d_sh0 = '0, d_sh1 = '0;
  int          d_bits = 0;
  int          adc_cs_cnt = 0, adc_upd_cnt = 0, dac_cs_cnt = 0;
  int          m_avg0 = 0, m_avg1 = 0;
  bit          want_avg = 0;
  logic        p_acs = 1'b1, p_asck = 1'b0;
  logic        p_dcs = 1'b1, p_dsck = 1'b0;

  function automatic void src_pair(input int k, output logic [11:0] d0,
                                   output logic [11:0] d1);
    if (k == 0) begin
      d0 = 12'd0; d1 = 12'd2088;
    end else if (k == 1) begin
      d0 = 12'd255; d1 = 12'd2088;
    end else if (k < 258) begin
      d0 = 12'(k - 2);
      d1 = 12'(11 * (k - 2) + 2088);
    end else begin
      d0 = 12'($urandom);
      d1 = 12'($urandom);
    end
  endfunction

  function automatic int avg_step(input int d, input int a);
    return (d / 8 + a / 8 + a / 4 + a / 2) % 4096;
  endfunction

  // One clock of bench activity, sampled on the falling clk edge.
  task automatic tick();
    logic [11:0] d0, d1;
    @(negedge clk);
    if (!reset_ni) begin
      exp0.delete(); exp1.delete();
      dexp0.delete(); dexp1.delete();
      m_avg0 = 0; m_avg1 = 0; want_avg = 0;
    end
    if (p_acs && !spi.adc_cs_no) begin
      src_pair(adc_cs_cnt, d0, d1);
      exp0.push_back(d0); exp1.push_back(d1);
      a_sh0 = {4'($urandom), d0};
      a_sh1 = {4'($urandom), d1};
      adc_cs_cnt++;
    end else if (!spi.adc_cs_no && p_asck && !spi.adc_sck_o) begin
      a_sh0 = {a_sh0[14:0], 1'b0};
      a_sh1 = {a_sh1[14:0], 1'b0};
    end
    spi.adc_miso_i = {a_sh1[15], a_sh0[15]};
    p_acs = spi.adc_cs_no;
    p_asck = spi.adc_sck_o;

    if (want_avg || avg_update_o) begin
      chk("avg_lag", 32'(avg_update_o), 32'(want_avg));
      if (want_avg) begin
        chk("avg0", 32'(avg0_o), 32'(m_avg0));
        chk("avg1", 32'(avg1_o), 32'(m_avg1));
        if (sw[1]) begin
          dexp0.push_back(12'(m_avg0));
          dexp1.push_back(12'(m_avg1));
        end
      end
    end
    want_avg = 0;
    if (adc_data_update_o) begin
      adc_upd_cnt++;
      if (exp0.size() == 0) begin
        chk("adc_extra", 32'd1, 32'd0);
      end else begin
        d0 = exp0.pop_front(); d1 = exp1.pop_front();
        chk("adc0", 32'(adc_data0_o), 32'(d0));
        chk("adc1", 32'(adc_data1_o), 32'(d1));
        m_avg0 = avg_step(int'(d0), m_avg0);
        m_avg1 = avg_step(int'(d1), m_avg1);
        want_avg = 1;
      end
    end

    if (p_dcs && !spi.dac_cs_no) begin
      d_bits = 0;
      dac_cs_cnt++;
    end
    if (!spi.dac_cs_no && !p_dsck && spi.dac_sck_o) begin
      d_sh0 = {d_sh0[14:0], spi.dac_mosi_o[0]};
      d_sh1 = {d_sh1[14:0], spi.dac_mosi_o[1]};
      d_bits++;
    end
    if (!p_dcs && spi.dac_cs_no && reset_ni) begin
      chk("dac_bits", 32'(d_bits), 32'd16);
      if (dexp0.size() == 0) begin
        chk("dac_extra", 32'd1, 32'd0);
      end else begin
        chk("dac0", 32'(d_sh0), {20'h0, 4'h0, dexp0.pop_front()});
        chk("dac1", 32'(d_sh1), {20'h0, 4'h0, dexp1.pop_front()});
      end
    end
    p_dcs = spi.dac_cs_no;
    p_dsck = spi.dac_sck_o;
  endtask

  task automatic wait_upd(input int n, input int budget, input string tag);
    int i = 0;
    while (adc_upd_cnt < n && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'(adc_upd_cnt >= n), 32'd1);
  endtask

  task automatic wait_cs_fall(input int budget, input string tag);
    int i = 0;
    while (spi.adc_cs_no && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'(spi.adc_cs_no), 32'd0);
  endtask

  initial begin
    int u, c, dc;
    spi.adc_miso_i = 2'b00;
    repeat (6) tick();
    chk("rst_adc_cs", 32'(spi.adc_cs_no), 32'd1);
    chk("rst_dac_cs", 32'(spi.dac_cs_no), 32'd1);
    chk("rst_sck", 32'({spi.adc_sck_o, spi.dac_sck_o}), 32'd0);
    chk("rst_mosi", 32'(spi.dac_mosi_o), 32'd0);
    chk("rst_adc_data", {8'h0, adc_data1_o, adc_data0_o}, 32'd0);
    chk("rst_avg", {8'h0, avg1_o, avg0_o}, 32'd0);
    chk("rst_pulses", 32'({adc_data_update_o, avg_update_o}), 32'd0);

    reset_ni = 1'b1;
    wait_cs_fall(SAMPLE_DIV, "first_cs_fall");

    wait_upd(1, 2 * SAMPLE_DIV, "upd1_seen");
    chk("first_d0", 32'(adc_data0_o), 32'd0);
    chk("first_d1", 32'(adc_data1_o), 32'd2088);
    tick();
    chk("first_avg_pulse", 32'(avg_update_o), 32'd1);
    chk("first_avg1", 32'(avg1_o), 32'd261);
    wait_upd(2, 2 * SAMPLE_DIV, "upd2_seen");
    tick();
    chk("second_avg1", 32'(avg1_o), 32'd488);
    chk("second_avg0", 32'(avg0_o), 32'd31);

    wait_upd(258, 260 * SAMPLE_DIV, "ramp_done");
    wait_upd(262, 6 * SAMPLE_DIV, "random_done");

    sw = 16'h0001;
    dc = dac_cs_cnt;
    u = adc_upd_cnt;
    wait_upd(u + 3, 5 * SAMPLE_DIV, "dac_off_adc_runs");
    repeat (100) tick();
    chk("dac_off_frames", 32'(dac_cs_cnt - dc), 32'd0);
    sw = 16'h0003;

    wait_cs_fall(2 * SAMPLE_DIV, "mid_cs_fall");
    repeat (20) tick();
    sw = 16'h0002;
    u = adc_upd_cnt;
    wait_upd(u + 1, 100, "mid_off_completes");
    c = adc_cs_cnt;
    repeat (3 * SAMPLE_DIV) tick();
    chk("adc_off_frames", 32'(adc_cs_cnt - c), 32'd0);

    sw = 16'h0003;
    wait_cs_fall(4, "rst_mid_cs_fall");
    repeat (2 + 8 * CLK_DIV) tick();
    u = adc_upd_cnt;
    reset_ni = 1'b0;
    #1;
    chk("rst_mid_cs", 32'(spi.adc_cs_no), 32'd1);
    chk("rst_mid_sck", 32'(spi.adc_sck_o), 32'd0);
    repeat (4) tick();
    chk("rst_mid_no_upd", 32'(adc_upd_cnt - u), 32'd0);
    chk("rst_mid_avg", {8'h0, avg1_o, avg0_o}, 32'd0);
    reset_ni = 1'b1;
    wait_upd(u + 3, 5 * SAMPLE_DIV, "post_rst_frames");
    repeat (100) tick();
    chk("dac_drained", 32'(dexp0.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
